// File: rtl/ipv_burst_scheduler.sv
// Round-robin burst scheduler sharing one serial IPV reducer among lanes.
// A granted lane streams exactly K beats into the reducer. Each finished
// burst is tagged with its lane id, and the tag is delayed so that it
// emerges together with the reducer's vov result.
module ipv_burst_scheduler #(
    parameter int N_LANES = 4,
    parameter int K       = 4,
    parameter int RED_LAT = 3,
    parameter int GAP     = 0,
    parameter int LW      = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_LANES-1:0] lane_req,
    input  logic [N_LANES-1:0] lane_bit,
    input  logic               hold,
    output logic [N_LANES-1:0] lane_pop,
    output logic               red_ipv_in,
    output logic               red_valid,
    output logic               res_valid,
    output logic [LW-1:0]      res_lane,
    output logic               busy
);

    localparam int BW = (K > 1) ? $clog2(K) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                      state_r, state_s;
    logic [LW-1:0]               grant_r, grant_s;
    logic [LW-1:0]               last_grant_r, last_grant_s;
    logic [BW-1:0]               beat_r, beat_s;
    logic [GW-1:0]               gap_cnt_r, gap_cnt_s;
    logic                        push_s;
    logic                        arb_s;
    logic                        start_s;
    logic [LW-1:0]               winner_s;
    logic [RED_LAT-1:0]          tag_v_r;
    logic [RED_LAT-1:0][LW-1:0]  tag_lane_r;

    // First requesting lane strictly after 'last', wrapping; 'last' itself
    // is examined last so a sole requester can win again.
    function automatic logic [LW-1:0] pick_winner(
        input logic [N_LANES-1:0] req,
        input logic [LW-1:0]      last
    );
        logic [LW-1:0] win;
        logic [LW-1:0] idx;
        logic          found;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= N_LANES; i++) begin
            idx = LW'((int'(last) + i) % N_LANES);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    assign winner_s = pick_winner(lane_req, last_grant_r);
    assign start_s  = arb_s && (|lane_req) && !hold;

    // Next-state logic: burst sequencing, gap timing and arbitration points.
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        beat_s       = beat_r;
        gap_cnt_s    = gap_cnt_r;
        push_s       = 1'b0;
        arb_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                arb_s = 1'b1;
            end
            ST_BURST: begin
                if (beat_r == BW'(K - 1)) begin
                    push_s = 1'b1;
                    beat_s = '0;
                    if (GAP > 0) begin
                        state_s   = ST_GAP;
                        gap_cnt_s = '0;
                    end else begin
                        state_s = ST_IDLE;
                        arb_s   = 1'b1;
                    end
                end else begin
                    beat_s = beat_r + BW'(1);
                end
            end
            ST_GAP: begin
                // The final gap cycle doubles as the arbitration cycle so a
                // waiting lane sees exactly GAP idle beats between bursts.
                if (gap_cnt_r == GW'(GAP - 1)) begin
                    state_s = ST_IDLE;
                    arb_s   = 1'b1;
                end else begin
                    gap_cnt_s = gap_cnt_r + GW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        if (start_s) begin
            state_s      = ST_BURST;
            grant_s      = winner_s;
            last_grant_s = winner_s;
            beat_s       = '0;
        end else begin
            grant_s      = grant_r;
            last_grant_s = last_grant_r;
        end
    end

    // Control state registers; lane 0 wins first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= LW'(N_LANES - 1);
            beat_r       <= '0;
            gap_cnt_r    <= '0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            beat_r       <= beat_s;
            gap_cnt_r    <= gap_cnt_s;
        end
    end

    // Tag pipeline: lane id of each finished burst, delayed to meet vov.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_r    <= '0;
            tag_lane_r <= '0;
        end else begin
            tag_v_r[0]    <= push_s;
            tag_lane_r[0] <= push_s ? grant_r : LW'(0);
            for (int i = 1; i < RED_LAT; i++) begin
                tag_v_r[i]    <= tag_v_r[i-1];
                tag_lane_r[i] <= tag_lane_r[i-1];
            end
        end
    end

    // Reducer feed: granted lane's head bit, all zero outside a burst.
    always_comb begin
        lane_pop   = '0;
        red_valid  = 1'b0;
        red_ipv_in = 1'b0;
        if (state_r == ST_BURST) begin
            lane_pop[grant_r] = 1'b1;
            red_valid         = 1'b1;
            red_ipv_in        = lane_bit[grant_r];
        end else begin
            lane_pop   = '0;
            red_valid  = 1'b0;
            red_ipv_in = 1'b0;
        end
    end

    assign res_valid = tag_v_r[RED_LAT-1];
    assign res_lane  = tag_lane_r[RED_LAT-1];
    assign busy      = (state_r != ST_IDLE) || (|tag_v_r);

endmodule

// File: tb/tb_ipv_burst_scheduler.sv
// Bench for ipv_burst_scheduler: two instances (GAP=0 and GAP=2) share the
// stimulus; each is compared every cycle against a transaction-level model,
// and directed scenarios pin the model with hand-computed values.
module tb_ipv_burst_scheduler;

    localparam int N  = 4;
    localparam int K  = 4;
    localparam int RL = 3;
    localparam int HN = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] lane_req = 4'd0;
    logic [3:0] lane_bit = 4'd0;
    logic       hold = 1'b0;

    logic [3:0] pop0, pop2;
    logic       ipv0, ipv2, val0, val2, rv0, rv2, busy0, busy2;
    logic [1:0] rl0, rl2;

    always #5 clk = ~clk;

    ipv_burst_scheduler #(.N_LANES(N), .K(K), .RED_LAT(RL), .GAP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .lane_req(lane_req), .lane_bit(lane_bit),
        .hold(hold), .lane_pop(pop0), .red_ipv_in(ipv0), .red_valid(val0),
        .res_valid(rv0), .res_lane(rl0), .busy(busy0));

    ipv_burst_scheduler #(.N_LANES(N), .K(K), .RED_LAT(RL), .GAP(2)) u2 (
        .clk(clk), .rst_n(rst_n), .lane_req(lane_req), .lane_bit(lane_bit),
        .hold(hold), .lane_pop(pop2), .red_ipv_in(ipv2), .red_valid(val2),
        .res_valid(rv2), .res_lane(rl2), .busy(busy2));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state per instance: burst in progress, owner, beats done,
    // remaining gap cycles, last winner, and scheduled result pulses.
    int m_active [2];
    int m_lane   [2];
    int m_beats  [2];
    int m_gap    [2];
    int m_last   [2];
    int q_due    [2][$];
    int q_lane   [2][$];

    logic [3:0] h_pop  [2][HN];
    logic       h_val  [2][HN];
    logic       h_ipv  [2][HN];
    logic       h_rv   [2][HN];
    logic [1:0] h_rl   [2][HN];
    logic       h_busy [2][HN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_out(input int i, output logic [3:0] e_pop, output logic e_val,
                             output logic e_ipv, output logic e_rv, output logic [1:0] e_rl,
                             output logic e_busy);
        e_pop = 4'd0; e_val = 1'b0; e_ipv = 1'b0; e_rv = 1'b0; e_rl = 2'd0; e_busy = 1'b0;
        if (rst_n) begin
            if (m_active[i] != 0) begin
                e_pop = 4'(1 << m_lane[i]);
                e_val = 1'b1;
                e_ipv = lane_bit[m_lane[i]];
            end
            foreach (q_due[i][j]) begin
                if (q_due[i][j] == cyc) begin
                    e_rv = 1'b1;
                    e_rl = 2'(q_lane[i][j]);
                end
            end
            e_busy = (m_active[i] != 0) || (m_gap[i] > 0) || (q_due[i].size() > 0);
        end
    endtask

    task automatic model_step(input int i);
        int  gap;
        int  w;
        bit  arb;
        gap = (i == 0) ? 0 : 2;
        if (!rst_n) begin
            m_active[i] = 0; m_lane[i] = 0; m_beats[i] = 0; m_gap[i] = 0; m_last[i] = N - 1;
            q_due[i].delete(); q_lane[i].delete();
            return;
        end
        while (q_due[i].size() > 0 && q_due[i][0] <= cyc) begin
            void'(q_due[i].pop_front());
            void'(q_lane[i].pop_front());
        end
        arb = 1'b0;
        if (m_active[i] != 0) begin
            if (m_beats[i] == K - 1) begin
                q_due[i].push_back(cyc + RL);
                q_lane[i].push_back(m_lane[i]);
                m_active[i] = 0;
                if (gap > 0) m_gap[i] = gap;
                else arb = 1'b1;
            end else begin
                m_beats[i]++;
            end
        end else if (m_gap[i] > 0) begin
            m_gap[i]--;
            if (m_gap[i] == 0) arb = 1'b1;
        end else begin
            arb = 1'b1;
        end
        if (arb && lane_req != 4'd0 && !hold) begin
            w = m_last[i];
            for (int s = 1; s <= N; s++) begin
                w = (m_last[i] + s) % N;
                if (lane_req[w]) break;
            end
            m_active[i] = 1; m_lane[i] = w; m_last[i] = w; m_beats[i] = 0;
        end
    endtask

    // Per-cycle comparison of both instances against the model, plus history.
    always @(negedge clk) begin
        logic [3:0] e_pop, a_pop;
        logic       e_val, e_ipv, e_rv, e_busy, a_val, a_ipv, a_rv, a_busy;
        logic [1:0] e_rl, a_rl;
        for (int i = 0; i < 2; i++) begin
            a_pop  = (i == 0) ? pop0  : pop2;
            a_val  = (i == 0) ? val0  : val2;
            a_ipv  = (i == 0) ? ipv0  : ipv2;
            a_rv   = (i == 0) ? rv0   : rv2;
            a_rl   = (i == 0) ? rl0   : rl2;
            a_busy = (i == 0) ? busy0 : busy2;
            model_out(i, e_pop, e_val, e_ipv, e_rv, e_rl, e_busy);
            chk($sformatf("lane_pop[g%0d]", i * 2), 32'(a_pop), 32'(e_pop));
            chk($sformatf("red_valid[g%0d]", i * 2), 32'(a_val), 32'(e_val));
            chk($sformatf("red_ipv_in[g%0d]", i * 2), 32'(a_ipv), 32'(e_ipv));
            chk($sformatf("res_valid[g%0d]", i * 2), 32'(a_rv), 32'(e_rv));
            chk($sformatf("res_lane[g%0d]", i * 2), 32'(a_rl), 32'(e_rl));
            chk($sformatf("busy[g%0d]", i * 2), 32'(a_busy), 32'(e_busy));
            if (cyc < HN) begin
                h_pop[i][cyc] = a_pop; h_val[i][cyc] = a_val; h_ipv[i][cyc] = a_ipv;
                h_rv[i][cyc] = a_rv; h_rl[i][cyc] = a_rl; h_busy[i][cyc] = a_busy;
            end
            model_step(i);
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; lane_req = 4'd0; hold = 1'b0; lane_bit = 4'd0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        logic [3:0] t1_bits;
        logic [3:0] t3_pop [5];
        t1_bits = 4'b1101;
        t3_pop[0] = 4'b0001; t3_pop[1] = 4'b0010; t3_pop[2] = 4'b0100;
        t3_pop[3] = 4'b1000; t3_pop[4] = 4'b0001;
        tick();
        chk("reset_pop", 32'(pop0), 32'd0);
        chk("reset_busy", 32'(busy0), 32'd0);

        // T1: single lane-0 burst, bits 1,0,1,1
        do_reset(); c = cyc; lane_req = 4'b0001;
        tick(); lane_req = 4'd0; lane_bit = 4'b0001;
        tick(); lane_bit = 4'b0000;
        tick(); lane_bit = 4'b0001;
        tick(); lane_bit = 4'b0001;
        tick(); lane_bit = 4'b0000;
        repeat (4) tick();
        for (int b = 0; b < 4; b++) begin
            chk("t1_pop", 32'(h_pop[0][c+1+b]), 32'd1);
            chk("t1_ipv", 32'(h_ipv[0][c+1+b]), 32'(t1_bits[b]));
        end
        chk("t1_no_early_res", 32'(h_rv[0][c+6]), 32'd0);
        chk("t1_res_valid", 32'(h_rv[0][c+7]), 32'd1);
        chk("t1_res_lane", 32'(h_rl[0][c+7]), 32'd0);
        chk("t1_idle_after", 32'(h_val[0][c+5]), 32'd0);

        // T2: lanes 0 and 1 back to back
        do_reset(); c = cyc; lane_req = 4'b0011;
        repeat (8) tick(); lane_req = 4'd0;
        repeat (6) tick();
        for (int b = 1; b <= 8; b++) chk("t2_valid_run", 32'(h_val[0][c+b]), 32'd1);
        chk("t2_pop_first", 32'(h_pop[0][c+1]), 32'd1);
        chk("t2_pop_second", 32'(h_pop[0][c+5]), 32'd2);
        chk("t2_res0", 32'(h_rv[0][c+7]), 32'd1);
        chk("t2_res0_lane", 32'(h_rl[0][c+7]), 32'd0);
        chk("t2_res1", 32'(h_rv[0][c+11]), 32'd1);
        chk("t2_res1_lane", 32'(h_rl[0][c+11]), 32'd1);
        chk("t2_stop", 32'(h_val[0][c+9]), 32'd0);

        // T3: all lanes requesting, five bursts
        do_reset(); c = cyc; lane_req = 4'b1111;
        repeat (17) tick(); lane_req = 4'd0;
        repeat (8) tick();
        for (int b = 0; b < 5; b++) chk("t3_order", 32'(h_pop[0][c+1+4*b]), 32'(t3_pop[b]));
        chk("t3_stop", 32'(h_val[0][c+21]), 32'd0);

        // T4: hold during a burst, then release
        c = cyc; lane_req = 4'b1111;
        tick(); tick(); hold = 1'b1;
        repeat (5) tick(); hold = 1'b0;
        tick(); lane_req = 4'd0;
        repeat (10) tick();
        for (int b = 1; b <= 4; b++) chk("t4_burst_done", 32'(h_val[0][c+b]), 32'd1);
        chk("t4_first_lane", 32'(h_pop[0][c+1]), 32'd2);
        chk("t4_held_idle", 32'(h_val[0][c+5]), 32'd0);
        chk("t4_held_idle2", 32'(h_val[0][c+7]), 32'd0);
        chk("t4_next_lane", 32'(h_pop[0][c+8]), 32'd4);

        // T5: reset mid-burst
        do_reset(); c = cyc; lane_req = 4'b1111;
        repeat (3) tick(); rst_n = 1'b0; lane_req = 4'b1010;
        tick(); tick(); rst_n = 1'b1;
        tick(); lane_req = 4'd0;
        repeat (8) tick();
        chk("t5_rst_val", 32'(h_val[0][c+3]), 32'd0);
        chk("t5_rst_pop", 32'(h_pop[0][c+3]), 32'd0);
        chk("t5_rst_busy", 32'(h_busy[0][c+3]), 32'd0);
        for (int b = 3; b <= 11; b++) chk("t5_no_res", 32'(h_rv[0][c+b]), 32'd0);
        chk("t5_lane1_first", 32'(h_pop[0][c+6]), 32'd2);
        chk("t5_res_lane1", 32'(h_rv[0][c+12]), 32'd1);
        chk("t5_res_lane1_id", 32'(h_rl[0][c+12]), 32'd1);

        // T6: GAP=2 instance with lane 0 held
        do_reset(); c = cyc; lane_req = 4'b0001;
        repeat (7) tick(); lane_req = 4'd0;
        repeat (9) tick();
        chk("t6_last_beat", 32'(h_val[1][c+4]), 32'd1);
        chk("t6_gap1", 32'(h_val[1][c+5]), 32'd0);
        chk("t6_gap2", 32'(h_val[1][c+6]), 32'd0);
        chk("t6_resume", 32'(h_val[1][c+7]), 32'd1);
        chk("t6_gap_busy", 32'(h_busy[1][c+5]), 32'd1);
        chk("t6_res_first", 32'(h_rv[1][c+7]), 32'd1);
        chk("t6_res_second", 32'(h_rv[1][c+13]), 32'd1);
        chk("t6_busy_last", 32'(h_busy[1][c+13]), 32'd1);
        chk("t6_busy_clear", 32'(h_busy[1][c+14]), 32'd0);

        // Randomized traffic with occasional hold and reset
        do_reset();
        repeat (2000) begin
            tick();
            lane_req = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'($urandom & $urandom);
            lane_bit = 4'($urandom);
            hold     = ($urandom_range(0, 9) == 0);
            rst_n    = ($urandom_range(0, 299) != 0);
        end
        rst_n = 1'b1; lane_req = 4'd0; hold = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
